exc_commit_unit: RTL and testbench
==================================

# exc_commit_unit

MEM→WB exception commit unit: the producer side of the `WB_CP0_Interface` that `cp0_reg` consumes.

- Collects per-instruction exception flags in MEM and qualifies pending interrupts against Status/Cause.
- Registers the winning exception into the WB bundle that drives CP0.
- Raises the pipeline flush and hands the redirect target (exception vector or EPC) to IF through a valid/ready handshake.

## Interface
- `EXC_VECTOR`, default 32'hBFC0_0380: general exception entry PC.
- `clk` in 1: clock, all state on posedge.
- `rst` in 1: reset, asynchronous, active-low (`RstEnable`).
- `MEM_Valid` in 1: MEM holds a real instruction.
- `MEM_PC` in 32: PC of the MEM instruction.
- `MEM_ALUOut` in 32: data address of the MEM instruction.
- `MEM_IsInDelaySlot` in 1: MEM instruction sits in a delay slot.
- `MEM_ExcFlags` in 8: {IFAdEL, RI, Sys, Brk, Eret, Ov, AdES, AdEL}, bit 7 to bit 0.
- `MEM_CP0Wr` in 1: the MEM instruction is an mtc0.
- `MEM_Dst` in 5: mtc0 destination register.
- `MEM_Result` in 32: mtc0 write data.
- `WB_Stall` in 1: hold the WB register.
- `CP0_Status`, `CP0_Cause`, `CP0_EPC` in 32 each: current CP0 values.
- `WCBus` out, `WB_CP0_Interface`: driven bundle (WB_CP0Wr, WB_Dst, WB_Result, WB_PC, WB_ALUOut, WB_IsInDelaySlot, WB_ExceptType).
- `Flush` out 1: one-cycle pipeline flush.
- `Redirect_Valid` out 1: redirect request to IF.
- `Redirect_PC` out 32: redirect target.
- `Redirect_Ready` in 1: IF accepts the redirect.

## Operation
- Interrupt pending when all three hold: Status[0]=1, Status[1]=0, and (Cause[15:8] & Status[15:8]) ≠ 0.
  - A pending interrupt attaches to the first MEM instruction with `MEM_Valid`=1; it is never attached to a bubble.
- Priority, highest first: Interrupt, IFAdEL, RI, Sys, Brk, Eret, Ov, AdES, AdEL. Only the winner is set in WB_ExceptType; all other bits are 0.
- Any exception or Eret in the captured instruction forces WB_CP0Wr=0.
- Capture rule: when `WB_Stall`=0, the WB register loads the MEM fields and the prioritized ExceptType. A MEM instruction with `MEM_Valid`=0 loads an all-zero bundle.
- FSM states: IDLE and REDIRECT.
  - IDLE → REDIRECT on a capture whose ExceptType is non-zero.
  - In REDIRECT, MEM captures load zero bundles, because squashed instructions must not raise exceptions.
  - REDIRECT → IDLE on the cycle where `Redirect_Valid` and `Redirect_Ready` are both 1.
- Redirect_PC:
  - Eret: EPC, sampled at capture, with forwarding applied under the configuration macro.
  - Any other exception: `EXC_VECTOR`.
  - Redirect_PC is held stable while in REDIRECT.

## Timing
- Reset values: WB bundle all 0, `Flush`=0, `Redirect_Valid`=0, `Redirect_PC`=0, state IDLE.
- Latency: MEM→WB is one cycle.
- `Flush` and `Redirect_Valid` assert in the same cycle the excepting instruction is visible in WB, which is the cycle CP0 commits it.
- `Flush` is exactly one cycle. It does not repeat while `WB_Stall` holds the bundle.
- `Redirect_Valid` stays at 1 until accepted. Ready in the first valid cycle gives a one-cycle request.
- `WB_Stall`=1 holds the bundle and defers interrupt attachment; the FSM still advances on the handshake.
- Reset mid-REDIRECT: state returns to IDLE and the request is dropped.

## Configuration
- `EXC_CP0_FWD_EN` defined:
  - Interrupt qualification overlays a WB mtc0 on the incoming CP0 values: Status[15:8] and Status[1:0] from WB_Result; Cause[9:8] from WB_Result.
  - The Eret target uses WB_Result when WB holds an mtc0 to EPC.
- `EXC_CP0_FWD_EN` undefined:
  - Raw CP0 inputs are used.
  - Interrupt attachment is inhibited for any cycle where WB holds an mtc0 to Status or Cause.
  - The Eret target is raw `CP0_EPC`.

## Structure
- Shared package holds:
  - the ExceptType bit-index constants;
  - the `EXC_VECTOR` default;
  - the FSM state enum;
  - the Status/Cause field-position constants (IE, EXL, IM, IP).
- One sub-module, `exc_prio_enc`: purely combinational priority encoder from {interrupt, MEM_ExcFlags} to a one-hot ExceptType.

## Test plan
- Syscall at PC 0xBFC0_0100, not in a delay slot:
  - WB_ExceptType.Syscall=1, WB_CP0Wr=0.
  - Flush is one cycle.
  - Redirect_PC=0xBFC0_0380, held 3 cycles with Ready low, dropped the cycle after Ready=1.
- Interrupt pending (Status=0x0000_0401, Cause=0x0000_0400) with MEM bubbles for 2 cycles, then a valid PC 0x8000_0010:
  - The interrupt attaches to 0x8000_0010 only.
- Ov and AdES in the same instruction:
  - Only Ov is set.
  - A following RI instruction captured during REDIRECT yields a zero bundle.
- Eret with CP0_EPC=0x8000_2000:
  - Redirect_PC=0x8000_2000.
- Eret immediately after mtc0 EPC=0x8000_3000:
  - With `EXC_CP0_FWD_EN` defined, Redirect_PC=0x8000_3000.
- mtc0 Status (IE=0) in WB while Cause IP set:
  - With forwarding, no interrupt is attached.
- Reset asserted while in REDIRECT:
  - Redirect_Valid=0 and Flush=0 immediately, without waiting for a clock edge.
  - State is IDLE after deassertion.

Source files
------------

// File: rtl/exc_commit_unit_pkg.sv
// Shared types and constants for the MEM->WB exception commit unit.
// ExceptType bit indices, CP0 field positions, FSM state and the WB->CP0 bundle.
package exc_commit_unit_pkg;

   localparam int EXC_W      = 9;
   localparam int EXC_ADEL   = 0;
   localparam int EXC_ADES   = 1;
   localparam int EXC_OV     = 2;
   localparam int EXC_ERET   = 3;
   localparam int EXC_BRK    = 4;
   localparam int EXC_SYS    = 5;
   localparam int EXC_RI     = 6;
   localparam int EXC_IFADEL = 7;
   localparam int EXC_INT    = 8;

   localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

   localparam logic [4:0] CP0_REG_STATUS = 5'd12;
   localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_REG_EPC    = 5'd14;

   localparam int ST_IE  = 0;
   localparam int ST_EXL = 1;
   localparam int IM_LO  = 8;
   localparam int IM_HI  = 15;
   localparam int IP_LO  = 8;
   localparam int IP_HI  = 15;

   typedef enum logic {
      S_IDLE,
      S_REDIRECT
   } exc_state_e;

   typedef struct packed {
      logic             cp0_wr;
      logic [4:0]       dst;
      logic [31:0]      result;
      logic [31:0]      pc;
      logic [31:0]      alu_out;
      logic             in_delay_slot;
      logic [EXC_W-1:0] except_type;
   } wb_cp0_bus_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: {interrupt, exception flags} -> one-hot ExceptType.
// The highest set bit wins (interrupt at the top, AdEL at the bottom).
module exc_prio_enc
   import exc_commit_unit_pkg::*;
(
   input  logic [EXC_W-1:0] req_i,
   output logic [EXC_W-1:0] onehot_o
);

   genvar gi;
   generate
      for (gi = 0; gi < EXC_W; gi++) begin : g_pri
         if (gi == EXC_W - 1) begin : g_top
            assign onehot_o[gi] = req_i[gi];
         end else begin : g_low
            assign onehot_o[gi] = req_i[gi] & ~(|req_i[EXC_W-1:gi+1]);
         end
      end
   endgenerate

endmodule

// File: rtl/exc_commit_unit.sv
// MEM->WB exception commit unit: registers the winning exception for CP0, pulses
// the flush and requests an IF redirect. Optional CP0 forwarding: EXC_CP0_FWD_EN.
module exc_commit_unit
   import exc_commit_unit_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        mem_valid_i,
   input  logic [31:0] mem_pc_i,
   input  logic [31:0] mem_alu_out_i,
   input  logic        mem_in_delay_slot_i,
   input  logic [7:0]  mem_exc_flags_i,
   input  logic        mem_cp0_wr_i,
   input  logic [4:0]  mem_dst_i,
   input  logic [31:0] mem_result_i,
   input  logic        wb_stall_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   output wb_cp0_bus_t wc_bus_o,
   output logic        flush_o,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o,
   input  logic        redirect_ready_i
);

   exc_state_e       state_q;
   wb_cp0_bus_t      wb_q, wb_d;
   logic             flush_q;
   logic             redirect_valid_q;
   logic [31:0]      redirect_pc_q;

   logic [31:0]      status_eff, cause_eff, epc_eff;
   logic             int_inhibit, int_pending;
   logic [EXC_W-1:0] exc_onehot;
   logic [31:0]      redirect_target;

   logic wb_mtc0_status, wb_mtc0_cause;
   assign wb_mtc0_status = wb_q.cp0_wr && (wb_q.dst == CP0_REG_STATUS);
   assign wb_mtc0_cause  = wb_q.cp0_wr && (wb_q.dst == CP0_REG_CAUSE);

`ifdef EXC_CP0_FWD_EN
   logic wb_mtc0_epc;
   assign wb_mtc0_epc = wb_q.cp0_wr && (wb_q.dst == CP0_REG_EPC);

   // CP0 has not yet seen the mtc0 sitting in WB, so overlay its fields here.
   always_comb begin
      status_eff  = cp0_status_i;
      cause_eff   = cp0_cause_i;
      int_inhibit = 1'b0;
      if (wb_mtc0_status) begin
         status_eff[IM_HI:IM_LO]  = wb_q.result[IM_HI:IM_LO];
         status_eff[ST_EXL:ST_IE] = wb_q.result[ST_EXL:ST_IE];
      end
      if (wb_mtc0_cause) begin
         cause_eff[9:8] = wb_q.result[9:8];
      end
      epc_eff = wb_mtc0_epc ? wb_q.result : cp0_epc_i;
   end
`else
   // Without forwarding, a Status/Cause write in flight makes the raw values stale.
   always_comb begin
      status_eff  = cp0_status_i;
      cause_eff   = cp0_cause_i;
      int_inhibit = wb_mtc0_status || wb_mtc0_cause;
      epc_eff     = cp0_epc_i;
   end
`endif

   logic unused_cp0_bits;
   assign unused_cp0_bits = ^{status_eff[31:16], status_eff[7:2],
                              cause_eff[31:16], cause_eff[7:0]};

   assign int_pending = status_eff[ST_IE] & ~status_eff[ST_EXL] & ~int_inhibit
                      & (|(cause_eff[IP_HI:IP_LO] & status_eff[IM_HI:IM_LO]));

   exc_prio_enc u_prio (
      .req_i    ({int_pending, mem_exc_flags_i}),
      .onehot_o (exc_onehot)
   );

   assign redirect_target = exc_onehot[EXC_ERET] ? epc_eff : EXC_VECTOR;

   // Bubbles and instructions squashed behind a pending redirect load a zero bundle.
   always_comb begin
      wb_d = '0;
      if ((state_q == S_IDLE) && mem_valid_i) begin
         wb_d.cp0_wr        = mem_cp0_wr_i && (exc_onehot == '0);
         wb_d.dst           = mem_dst_i;
         wb_d.result        = mem_result_i;
         wb_d.pc            = mem_pc_i;
         wb_d.alu_out       = mem_alu_out_i;
         wb_d.in_delay_slot = mem_in_delay_slot_i;
         wb_d.except_type   = exc_onehot;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q          <= S_IDLE;
         wb_q             <= '0;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         flush_q <= 1'b0;
         if (!wb_stall_i) begin
            wb_q <= wb_d;
         end
         case (state_q)
            S_IDLE: begin
               if (!wb_stall_i && (wb_d.except_type != '0)) begin
                  state_q          <= S_REDIRECT;
                  flush_q          <= 1'b1;
                  redirect_valid_q <= 1'b1;
                  redirect_pc_q    <= redirect_target;
               end
            end
            S_REDIRECT: begin
               if (redirect_valid_q && redirect_ready_i) begin
                  state_q          <= S_IDLE;
                  redirect_valid_q <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign wc_bus_o         = wb_q;
   assign flush_o          = flush_q;
   assign redirect_valid_o = redirect_valid_q;
   assign redirect_pc_o    = redirect_pc_q;

endmodule

// File: tb/tb_exc_commit_unit.sv
// Self-checking bench for exc_commit_unit: directed scenarios followed by random
// traffic, all compared every cycle against a behavioural model of the commit rules.
module tb_exc_commit_unit;
   import exc_commit_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        mem_valid, mem_in_delay_slot, mem_cp0_wr, wb_stall, redirect_ready;
   logic [31:0] mem_pc, mem_alu_out, mem_result, cp0_status, cp0_cause, cp0_epc;
   logic [7:0]  mem_flags;
   logic [4:0]  mem_dst;
   wb_cp0_bus_t wc_bus;
   logic        flush, redirect_valid;
   logic [31:0] redirect_pc;

   always #5 clk = ~clk;

   exc_commit_unit dut (
      .clk_i               (clk),
      .rst_ni              (rst_ni),
      .mem_valid_i         (mem_valid),
      .mem_pc_i            (mem_pc),
      .mem_alu_out_i       (mem_alu_out),
      .mem_in_delay_slot_i (mem_in_delay_slot),
      .mem_exc_flags_i     (mem_flags),
      .mem_cp0_wr_i        (mem_cp0_wr),
      .mem_dst_i           (mem_dst),
      .mem_result_i        (mem_result),
      .wb_stall_i          (wb_stall),
      .cp0_status_i        (cp0_status),
      .cp0_cause_i         (cp0_cause),
      .cp0_epc_i           (cp0_epc),
      .wc_bus_o            (wc_bus),
      .flush_o             (flush),
      .redirect_valid_o    (redirect_valid),
      .redirect_pc_o       (redirect_pc),
      .redirect_ready_i    (redirect_ready)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state: what WB and the redirect port should look like.
   wb_cp0_bus_t m_bus;
   bit          m_flush, m_rv, m_pending;
   logic [31:0] m_rpc;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_bus = '0; m_flush = 0; m_rv = 0; m_pending = 0; m_rpc = '0;
   endtask

   // Highest-priority request wins: Int, IFAdEL, RI, Sys, Brk, Eret, Ov, AdES, AdEL.
   function automatic logic [8:0] prio(input logic [8:0] req);
      int order [9];
      logic [8:0] r;
      order = '{8, 7, 6, 5, 4, 3, 2, 1, 0};
      r = '0;
      foreach (order[k]) begin
         if (req[order[k]]) begin
            r[order[k]] = 1'b1;
            return r;
         end
      end
      return r;
   endfunction

   function automatic bit model_int();
      logic [31:0] st, ca;
      st = cp0_status;
      ca = cp0_cause;
`ifdef EXC_CP0_FWD_EN
      if (m_bus.cp0_wr && m_bus.dst == 5'd12) begin
         st[15:8] = m_bus.result[15:8];
         st[1:0]  = m_bus.result[1:0];
      end
      if (m_bus.cp0_wr && m_bus.dst == 5'd13) ca[9:8] = m_bus.result[9:8];
`else
      if (m_bus.cp0_wr && (m_bus.dst == 5'd12 || m_bus.dst == 5'd13)) return 1'b0;
`endif
      return st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'h00);
   endfunction

   function automatic logic [31:0] model_epc();
`ifdef EXC_CP0_FWD_EN
      if (m_bus.cp0_wr && m_bus.dst == 5'd14) return m_bus.result;
`endif
      return cp0_epc;
   endfunction

   // One clock: predict from the inputs now applied, advance, compare all outputs.
   task automatic step();
      wb_cp0_bus_t nb;
      bit          nf, nrv, npend;
      logic [31:0] nrpc;
      logic [8:0]  et;
      nb = m_bus; nf = 0; nrv = m_rv; npend = m_pending; nrpc = m_rpc;
      if (m_pending && redirect_ready) begin
         npend = 0;
         nrv   = 0;
      end
      if (!wb_stall) begin
         nb = '0;
         if (!m_pending && mem_valid) begin
            et = prio({model_int(), mem_flags});
            nb.pc            = mem_pc;
            nb.alu_out       = mem_alu_out;
            nb.in_delay_slot = mem_in_delay_slot;
            nb.dst           = mem_dst;
            nb.result        = mem_result;
            nb.except_type   = et;
            nb.cp0_wr        = mem_cp0_wr && (et == 9'd0);
            if (et != 9'd0) begin
               nf = 1; npend = 1; nrv = 1;
               nrpc = et[3] ? model_epc() : 32'hBFC0_0380;
            end
         end
      end
      @(posedge clk);
      #1;
      m_bus = nb; m_flush = nf; m_rv = nrv; m_pending = npend; m_rpc = nrpc;
      $display("t=%0t valid=%0b flags=%h stall=%0b rdy=%0b -> exc=%h flush=%0b rv=%0b rpc=%h",
               $time, mem_valid, mem_flags, wb_stall, redirect_ready,
               wc_bus.except_type, flush, redirect_valid, redirect_pc);
      chk("cyc_bus", 128'(wc_bus), 128'(m_bus));
      chk("cyc_flush", 128'(flush), 128'(m_flush));
      chk("cyc_rvalid", 128'(redirect_valid), 128'(m_rv));
      chk("cyc_rpc", 128'(redirect_pc), 128'(m_rpc));
   endtask

   task automatic idle_inputs();
      mem_valid = 0; mem_flags = '0; mem_cp0_wr = 0; mem_dst = '0; mem_result = '0;
      mem_in_delay_slot = 0; wb_stall = 0; redirect_ready = 0;
      mem_pc = $urandom; mem_alu_out = $urandom;
   endtask

   // Retire any outstanding redirect, bounded so a stuck request cannot hang the run.
   task automatic drain();
      idle_inputs();
      redirect_ready = 1;
      for (int i = 0; i < 20 && m_rv; i++) step();
      step();
      chk("drain_rvalid", 128'(redirect_valid), 128'(0));
      idle_inputs();
   endtask

   initial begin
      rst_ni = 1;
      idle_inputs();
      cp0_status = '0; cp0_cause = '0; cp0_epc = '0;
      model_reset();
      #2 rst_ni = 0;
      #1;
      chk("rst_bus", 128'(wc_bus), 128'(0));
      chk("rst_flush", 128'(flush), 128'(0));
      chk("rst_rvalid", 128'(redirect_valid), 128'(0));
      chk("rst_rpc", 128'(redirect_pc), 128'(0));
      @(negedge clk);
      rst_ni = 1;

      // Syscall: redirect to the vector, held while Ready is low.
      mem_valid = 1; mem_pc = 32'hBFC0_0100; mem_flags = 8'h20;
      mem_cp0_wr = 1; mem_dst = 5'd12;
      step();
      chk("sys_type", 128'(wc_bus.except_type), 128'(9'h020));
      chk("sys_cp0wr", 128'(wc_bus.cp0_wr), 128'(0));
      chk("sys_pc", 128'(wc_bus.pc), 128'(32'hBFC0_0100));
      chk("sys_flush", 128'(flush), 128'(1));
      chk("sys_rpc", 128'(redirect_pc), 128'(32'hBFC0_0380));
      idle_inputs();
      repeat (3) begin
         step();
         chk("sys_flush_once", 128'(flush), 128'(0));
         chk("sys_rv_held", 128'(redirect_valid), 128'(1));
         chk("sys_rpc_held", 128'(redirect_pc), 128'(32'hBFC0_0380));
      end
      redirect_ready = 1;
      step();
      chk("sys_rv_drop", 128'(redirect_valid), 128'(0));
      idle_inputs();

      // Interrupt never rides on a bubble.
      cp0_status = 32'h0000_0401; cp0_cause = 32'h0000_0400;
      repeat (2) begin
         step();
         chk("int_bubble_type", 128'(wc_bus.except_type), 128'(0));
         chk("int_bubble_rv", 128'(redirect_valid), 128'(0));
      end
      mem_valid = 1; mem_pc = 32'h8000_0010;
      step();
      chk("int_type", 128'(wc_bus.except_type), 128'(9'h100));
      chk("int_pc", 128'(wc_bus.pc), 128'(32'h8000_0010));
      cp0_status = '0; cp0_cause = '0;
      drain();

      // Ov beats AdES; the next instruction is squashed.
      mem_valid = 1; mem_flags = 8'h06;
      step();
      chk("ov_type", 128'(wc_bus.except_type), 128'(9'h004));
      mem_flags = 8'h40; mem_pc = 32'h8000_0104;
      step();
      chk("ri_squashed", 128'(wc_bus), 128'(0));
      chk("ri_no_flush", 128'(flush), 128'(0));
      drain();

      // Eret goes to EPC.
      cp0_epc = 32'h8000_2000;
      mem_valid = 1; mem_flags = 8'h08;
      step();
      chk("eret_type", 128'(wc_bus.except_type), 128'(9'h008));
      chk("eret_rpc", 128'(redirect_pc), 128'(32'h8000_2000));
      drain();

      // mtc0 EPC immediately followed by Eret.
      mem_valid = 1; mem_cp0_wr = 1; mem_dst = 5'd14; mem_result = 32'h8000_3000;
      step();
      chk("mtc0_epc_wr", 128'(wc_bus.cp0_wr), 128'(1));
      mem_cp0_wr = 0; mem_flags = 8'h08;
      step();
`ifdef EXC_CP0_FWD_EN
      chk("eret_fwd_rpc", 128'(redirect_pc), 128'(32'h8000_3000));
`else
      chk("eret_raw_rpc", 128'(redirect_pc), 128'(32'h8000_2000));
`endif
      drain();

      // mtc0 Status with IE=0 in WB while Cause IP is set.
      cp0_status = 32'h0000_0400; cp0_cause = 32'h0000_0400;
      mem_valid = 1; mem_cp0_wr = 1; mem_dst = 5'd12; mem_result = 32'h0000_0400;
      step();
      chk("mtc0_st_type", 128'(wc_bus.except_type), 128'(0));
      cp0_status = 32'h0000_0401; mem_cp0_wr = 0;
      step();
      chk("mtc0_st_noint", 128'(wc_bus.except_type), 128'(0));
      chk("mtc0_st_norv", 128'(redirect_valid), 128'(0));
      cp0_status = '0; cp0_cause = '0;
      drain();

      // Reset while a redirect is outstanding.
      mem_valid = 1; mem_flags = 8'h20;
      step();
      #2 rst_ni = 0;
      #1;
      chk("arst_rvalid", 128'(redirect_valid), 128'(0));
      chk("arst_flush", 128'(flush), 128'(0));
      model_reset();
      idle_inputs();
      @(negedge clk);
      rst_ni = 1;
      step();
      mem_valid = 1; mem_flags = 8'h10;
      step();
      chk("post_rst_flush", 128'(flush), 128'(1));
      chk("post_rst_type", 128'(wc_bus.except_type), 128'(9'h010));
      drain();

      // Random traffic against the model.
      repeat (400) begin
         mem_valid = ($urandom_range(3) != 0);
         mem_flags = ($urandom_range(5) == 0) ? 8'($urandom) : 8'h00;
         mem_cp0_wr = ($urandom_range(3) == 0);
         case ($urandom_range(3))
            0: mem_dst = 5'd12;
            1: mem_dst = 5'd13;
            2: mem_dst = 5'd14;
            default: mem_dst = 5'($urandom);
         endcase
         mem_result = $urandom;
         mem_pc = $urandom; mem_alu_out = $urandom;
         mem_in_delay_slot = 1'($urandom);
         wb_stall = ($urandom_range(4) == 0);
         redirect_ready = 1'($urandom);
         cp0_status = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
         cp0_cause = ($urandom_range(2) == 0) ? ($urandom & 32'h0000_FF00) : 32'h0;
         cp0_epc = $urandom;
         step();
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
